// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS pipeline fetch slice: constants, fetch FSM
// encoding and the IF/ID bundle layout.
package mips_pkg;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam logic [31:0] NOP_INST = 32'h0000_0000;

  typedef logic [1:0] fetch_state_t;

  localparam fetch_state_t FS_IDLE = 2'd0;
  localparam fetch_state_t FS_REQ  = 2'd1;
  localparam fetch_state_t FS_HOLD = 2'd2;
  localparam fetch_state_t FS_DROP = 2'd3;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
    logic        valid;
  } ifid_t;

  localparam ifid_t IFID_BUBBLE = '{pc: 32'h0, inst: NOP_INST, valid: 1'b0};

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register. A bubble keeps the PC field and replaces the
// instruction with a NOP; with neither load nor bubble the contents hold.
module if_id_reg #(
  parameter logic [31:0] NOP_INST = mips_pkg::NOP_INST
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_load,
  input  logic        i_bubble,
  input  logic [31:0] i_pc,
  input  logic [31:0] i_inst,
  output logic [31:0] o_pc,
  output logic [31:0] o_inst,
  output logic        o_valid
);
  import mips_pkg::*;

  ifid_t r_ifid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ifid <= '{pc: IFID_BUBBLE.pc, inst: NOP_INST, valid: 1'b0};
    end else if (i_bubble) begin
      r_ifid.inst  <= NOP_INST;
      r_ifid.valid <= 1'b0;
    end else if (i_load) begin
      r_ifid <= '{pc: i_pc, inst: i_inst, valid: 1'b1};
    end
  end

  assign o_pc    = r_ifid.pc;
  assign o_inst  = r_ifid.inst;
  assign o_valid = r_ifid.valid;

endmodule

// File: rtl/if_stage.sv
// Instruction fetch stage: PC register, req/ack imem handshake and the IF/ID
// register, with load-use stall and branch redirect handling.
module if_stage #(
  parameter logic [31:0] RESET_PC = mips_pkg::RESET_PC,
  parameter logic [31:0] NOP_INST = mips_pkg::NOP_INST
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        PCSrc,
  input  logic [31:0] branch_target,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] IFtoID_PC,
  output logic [31:0] IFtoID_inst,
  output logic        IFtoID_valid
);
  import mips_pkg::*;

  fetch_state_t r_state;
  logic [31:0]  r_pc;
  logic [31:0]  r_tgt;
  logic [31:0]  r_buf;

  fetch_state_t w_next_state;
  logic [31:0]  w_next_pc;
  logic [31:0]  w_next_tgt;
  logic [31:0]  w_next_buf;
  logic [31:0]  w_pc_plus4;
  logic         w_ifid_load;
  logic         w_ifid_bubble;
  logic [31:0]  w_ifid_inst;

  assign w_pc_plus4 = r_pc + 32'd4;

  // Redirect always beats stall: a held or in-flight word is wrong-path once
  // PCSrc fires, so it is dropped and IF/ID becomes a bubble.
  always_comb begin
    w_next_state  = r_state;
    w_next_pc     = r_pc;
    w_next_tgt    = r_tgt;
    w_next_buf    = r_buf;
    w_ifid_load   = 1'b0;
    w_ifid_bubble = 1'b0;
    w_ifid_inst   = imem_rdata;
    case (r_state)
      FS_IDLE: w_next_state = FS_REQ;
      FS_REQ: begin
        if (PCSrc && imem_ack) begin
          w_next_pc     = branch_target;
          w_ifid_bubble = 1'b1;
        end else if (PCSrc) begin
          w_next_tgt    = branch_target;
          w_ifid_bubble = 1'b1;
          w_next_state  = FS_DROP;
        end else if (imem_ack && !stall) begin
          w_ifid_load = 1'b1;
          w_next_pc   = w_pc_plus4;
        end else if (imem_ack) begin
          w_next_buf   = imem_rdata;
          w_next_state = FS_HOLD;
        end else if (!stall) begin
          w_ifid_bubble = 1'b1;
        end
      end
      FS_HOLD: begin
        if (PCSrc) begin
          w_next_pc     = branch_target;
          w_ifid_bubble = 1'b1;
          w_next_state  = FS_REQ;
        end else if (!stall) begin
          w_ifid_load  = 1'b1;
          w_ifid_inst  = r_buf;
          w_next_pc    = w_pc_plus4;
          w_next_state = FS_REQ;
        end
      end
      FS_DROP: begin
        // The abandoned request must still complete; the newest target wins.
        w_ifid_bubble = 1'b1;
        if (imem_ack) begin
          w_next_pc    = PCSrc ? branch_target : r_tgt;
          w_next_state = FS_REQ;
        end else if (PCSrc) begin
          w_next_tgt = branch_target;
        end
      end
      default: w_next_state = FS_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= FS_IDLE;
      r_pc    <= RESET_PC;
      r_tgt   <= 32'h0;
      r_buf   <= 32'h0;
    end else begin
      r_state <= w_next_state;
      r_pc    <= w_next_pc;
      r_tgt   <= w_next_tgt;
      r_buf   <= w_next_buf;
    end
  end

  assign imem_req  = (r_state == FS_REQ) || (r_state == FS_DROP);
  assign imem_addr = r_pc;

  if_id_reg #(
    .NOP_INST(NOP_INST)
  ) u_if_id_reg (
    .clk     (clk),
    .rst_n   (rst),
    .i_load  (w_ifid_load),
    .i_bubble(w_ifid_bubble),
    .i_pc    (w_pc_plus4),
    .i_inst  (w_ifid_inst),
    .o_pc    (IFtoID_PC),
    .o_inst  (IFtoID_inst),
    .o_valid (IFtoID_valid)
  );

endmodule

// File: tb/tb_if_stage.sv
// Self-checking bench for if_stage: directed scenarios plus randomized
// traffic, compared against a transaction-level fetch model.
module tb_if_stage;

  localparam logic [31:0] NOP   = 32'h0000_0000;
  localparam logic [31:0] SALT  = 32'hA5A5_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        stall = 1'b0;
  logic        PCSrc = 1'b0;
  logic [31:0] branch_target = 32'h0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack = 1'b0;
  logic [31:0] imem_rdata = 32'h0;
  logic [31:0] IFtoID_PC;
  logic [31:0] IFtoID_inst;
  logic        IFtoID_valid;

  int passCnt  = 0;
  int checkCnt = 0;

  if_stage dut (
    .clk          (clk),
    .rst          (rst),
    .stall        (stall),
    .PCSrc        (PCSrc),
    .branch_target(branch_target),
    .imem_req     (imem_req),
    .imem_addr    (imem_addr),
    .imem_ack     (imem_ack),
    .imem_rdata   (imem_rdata),
    .IFtoID_PC    (IFtoID_PC),
    .IFtoID_inst  (IFtoID_inst),
    .IFtoID_valid (IFtoID_valid)
  );

  always #5 clk = ~clk;

  // Fetch model: a started flag, the program counter, at most one word
  // parked by a stall, at most one pending redirect target while the
  // abandoned request drains, and the instruction handed to decode.
  bit          mStarted;
  logic [31:0] mPc;
  logic [31:0] mHeld[$];
  logic [31:0] mPendingTgt[$];
  logic [31:0] mIfPc;
  logic [31:0] mIfInst;
  bit          mIfValid;

  int gLat;
  int waitCnt;

  function automatic bit mReq();
    return mStarted && (mHeld.size() == 0);
  endfunction

  function automatic logic [97:0] expBundle();
    return {mReq(), mPc, mIfValid, mIfPc, mIfInst};
  endfunction

  function automatic logic [97:0] dutBundle();
    return {imem_req, imem_addr, IFtoID_valid, IFtoID_PC, IFtoID_inst};
  endfunction

  task automatic modelReset();
    mStarted = 0;
    mPc      = 32'h0;
    mHeld.delete();
    mPendingTgt.delete();
    mIfPc    = 32'h0;
    mIfInst  = NOP;
    mIfValid = 0;
    waitCnt  = 0;
  endtask

  task automatic modelBubble();
    mIfInst  = NOP;
    mIfValid = 0;
  endtask

  task automatic modelDeliver(input logic [31:0] word);
    mPc      = mPc + 32'd4;
    mIfPc    = mPc;
    mIfInst  = word;
    mIfValid = 1;
  endtask

  task automatic modelEdge(input bit st, input bit pcs, input logic [31:0] tgt,
                           input bit ack, input logic [31:0] data);
    if (!mStarted) begin
      mStarted = 1;
    end else if (mHeld.size() != 0) begin
      if (pcs) begin
        mHeld.delete();
        mPc = tgt;
        modelBubble();
      end else if (!st) begin
        modelDeliver(mHeld.pop_front());
      end
    end else if (mPendingTgt.size() != 0) begin
      modelBubble();
      if (pcs) mPendingTgt[0] = tgt;
      if (ack) mPc = mPendingTgt.pop_front();
    end else if (pcs) begin
      modelBubble();
      if (ack) mPc = tgt;
      else mPendingTgt.push_back(tgt);
    end else if (ack) begin
      if (st) mHeld.push_back(data);
      else modelDeliver(data);
    end else if (!st) begin
      modelBubble();
    end
  endtask

  // One clock: memory answers per the latency setting (gLat<0 = random).
  task automatic cycle(input bit st, input bit pcs, input logic [31:0] tgt);
    bit          ack;
    bit          reqNow;
    logic [31:0] data;
    reqNow = mReq();
    ack    = 0;
    if (reqNow) ack = (gLat < 0) ? bit'($urandom % 2) : (waitCnt >= gLat);
    data = ack ? (mPc ^ SALT) : $urandom;
    stall         = st;
    PCSrc         = pcs;
    branch_target = tgt;
    imem_ack      = ack;
    imem_rdata    = data;
    @(posedge clk);
    modelEdge(st, pcs, tgt, ack, data);
    if (ack) waitCnt = 0;
    else if (reqNow) waitCnt++;
    #1;
  endtask

  task automatic doReset();
    rst      = 1'b0;
    imem_ack = 1'b0;
    stall    = 1'b0;
    PCSrc    = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b1;
    modelReset();
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    modelReset();
    checkCnt++;
    if ({imem_req, imem_addr, IFtoID_valid, IFtoID_PC, IFtoID_inst} !== {1'b0, 32'h0, 1'b0, 32'h0, NOP})
      $display("[TB] FAIL reset_values got %h exp %h", dutBundle(),
               {1'b0, 32'h0, 1'b0, 32'h0, NOP});
    else passCnt++;
    rst  = 1'b1;
    gLat = 0;
    #2;
    checkCnt++;
    if (imem_req !== 1'b0) $display("[TB] FAIL req_after_release got %b exp 0", imem_req);
    else passCnt++;
    cycle(0, 0, 0);
    checkCnt++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h0)
      $display("[TB] FAIL first_req got req=%b addr=%h exp req=1 addr=0", imem_req, imem_addr);
    else passCnt++;
  endtask

  task automatic test_streaming();
    for (int i = 1; i <= 6; i++) begin
      cycle(0, 0, 0);
      checkCnt++;
      if ({IFtoID_valid, IFtoID_PC, IFtoID_inst} !== {1'b1, 32'(4 * i), 32'(4 * (i - 1)) ^ SALT})
        $display("[TB] FAIL stream_%0d got v=%b pc=%h inst=%h exp v=1 pc=%h inst=%h", i,
                 IFtoID_valid, IFtoID_PC, IFtoID_inst, 32'(4 * i), 32'(4 * (i - 1)) ^ SALT);
      else passCnt++;
    end
  endtask

  task automatic test_stall();
    doReset();
    gLat = 0;
    for (int i = 0; i < 20 && !(mStarted && mPc == 32'h10); i++) begin
      cycle(0, 0, 0);
      checkCnt++;
      if (dutBundle() !== expBundle())
        $display("[TB] FAIL stall_lead got %h exp %h", dutBundle(), expBundle());
      else passCnt++;
    end
    for (int i = 0; i < 3; i++) begin
      cycle(1, 0, 0);
      checkCnt++;
      if ({imem_req, IFtoID_valid, IFtoID_PC, IFtoID_inst} !== {1'b0, 1'b1, 32'h10, 32'h0C ^ SALT})
        $display("[TB] FAIL stall_hold_%0d got req=%b v=%b pc=%h inst=%h exp req=0 v=1 pc=10 inst=%h",
                 i, imem_req, IFtoID_valid, IFtoID_PC, IFtoID_inst, 32'h0C ^ SALT);
      else passCnt++;
    end
    cycle(0, 0, 0);
    checkCnt++;
    if ({imem_req, imem_addr, IFtoID_valid, IFtoID_PC, IFtoID_inst} !== {1'b1, 32'h14, 1'b1, 32'h14, 32'h10 ^ SALT})
      $display("[TB] FAIL stall_release got %h exp %h", dutBundle(),
               {1'b1, 32'h14, 1'b1, 32'h14, 32'h10 ^ SALT});
    else passCnt++;
    cycle(0, 0, 0);
    checkCnt++;
    if ({IFtoID_PC, IFtoID_inst} !== {32'h18, 32'h14 ^ SALT})
      $display("[TB] FAIL stall_resume got pc=%h inst=%h exp pc=18 inst=%h",
               IFtoID_PC, IFtoID_inst, 32'h14 ^ SALT);
    else passCnt++;
  endtask

  task automatic test_slow_memory();
    int valids;
    doReset();
    gLat   = 2;
    valids = 0;
    cycle(0, 0, 0);
    for (int i = 0; i < 9; i++) begin
      cycle(0, 0, 0);
      if (IFtoID_valid === 1'b1) valids++;
      checkCnt++;
      if (dutBundle() !== expBundle())
        $display("[TB] FAIL slow_cycle_%0d got %h exp %h", i, dutBundle(), expBundle());
      else passCnt++;
    end
    checkCnt++;
    if (valids != 3) $display("[TB] FAIL slow_valid_count got %0d exp 3", valids);
    else passCnt++;
  endtask

  task automatic test_redirect_outstanding();
    bit seenNew;
    bit done;
    doReset();
    gLat    = 2;
    seenNew = 0;
    done    = 0;
    for (int i = 0; i < 60 && !(mReq() && mPc == 32'h20 && waitCnt == 0); i++) cycle(0, 0, 0);
    cycle(0, 1, 32'h400);
    checkCnt++;
    if ({imem_req, imem_addr, IFtoID_valid} !== {1'b1, 32'h20, 1'b0})
      $display("[TB] FAIL redirect_drop got req=%b addr=%h v=%b exp req=1 addr=20 v=0",
               imem_req, imem_addr, IFtoID_valid);
    else passCnt++;
    for (int i = 0; i < 20 && !done; i++) begin
      cycle(0, 0, 0);
      if (!seenNew && imem_addr !== 32'h20) begin
        seenNew = 1;
        checkCnt++;
        if (imem_addr !== 32'h400) $display("[TB] FAIL redirect_addr got %h exp 400", imem_addr);
        else passCnt++;
      end
      if (IFtoID_valid === 1'b1) begin
        done = 1;
        checkCnt++;
        if ({IFtoID_PC, IFtoID_inst} !== {32'h404, 32'h400 ^ SALT})
          $display("[TB] FAIL redirect_first got pc=%h inst=%h exp pc=404 inst=%h",
                   IFtoID_PC, IFtoID_inst, 32'h400 ^ SALT);
        else passCnt++;
      end
    end
    checkCnt++;
    if (!done || !seenNew) $display("[TB] FAIL redirect_timeout got done=%b seen=%b exp 1 1", done, seenNew);
    else passCnt++;
  endtask

  task automatic test_redirect_with_stall();
    doReset();
    gLat = 0;
    repeat (4) cycle(0, 0, 0);
    cycle(1, 1, 32'h80);
    checkCnt++;
    if ({imem_addr, IFtoID_valid, IFtoID_inst} !== {32'h80, 1'b0, NOP})
      $display("[TB] FAIL redir_stall_req got addr=%h v=%b inst=%h exp addr=80 v=0 inst=%h",
               imem_addr, IFtoID_valid, IFtoID_inst, NOP);
    else passCnt++;
    cycle(1, 0, 0);
    cycle(1, 1, 32'h100);
    checkCnt++;
    if ({imem_req, imem_addr, IFtoID_valid, IFtoID_inst} !== {1'b1, 32'h100, 1'b0, NOP})
      $display("[TB] FAIL redir_stall_hold got %h exp %h", dutBundle(), expBundle());
    else passCnt++;
    cycle(0, 0, 0);
    checkCnt++;
    if ({IFtoID_valid, IFtoID_PC, IFtoID_inst} !== {1'b1, 32'h104, 32'h100 ^ SALT})
      $display("[TB] FAIL redir_stall_after got v=%b pc=%h inst=%h exp v=1 pc=104 inst=%h",
               IFtoID_valid, IFtoID_PC, IFtoID_inst, 32'h100 ^ SALT);
    else passCnt++;
  endtask

  task automatic test_async_reset();
    doReset();
    gLat = 2;
    cycle(0, 0, 0);
    cycle(0, 1, 32'h200);
    cycle(0, 0, 0);
    #3;
    rst = 1'b0;
    #1;
    checkCnt++;
    if ({imem_req, imem_addr, IFtoID_valid, IFtoID_PC, IFtoID_inst} !== {1'b0, 32'h0, 1'b0, 32'h0, NOP})
      $display("[TB] FAIL async_reset got %h exp %h", dutBundle(), {1'b0, 32'h0, 1'b0, 32'h0, NOP});
    else passCnt++;
    modelReset();
    @(posedge clk);
    #1;
    rst = 1'b1;
    cycle(0, 0, 0);
    checkCnt++;
    if ({imem_req, imem_addr} !== {1'b1, 32'h0})
      $display("[TB] FAIL async_restart got req=%b addr=%h exp req=1 addr=0", imem_req, imem_addr);
    else passCnt++;
  endtask

  task automatic test_wrap();
    doReset();
    gLat = 0;
    cycle(0, 0, 0);
    cycle(0, 1, 32'hFFFF_FFF8);
    repeat (2) cycle(0, 0, 0);
    checkCnt++;
    if ({IFtoID_PC, IFtoID_inst, imem_addr} !== {32'h0, 32'hFFFF_FFFC ^ SALT, 32'h0})
      $display("[TB] FAIL pc_wrap got pc=%h inst=%h addr=%h exp pc=0 inst=%h addr=0",
               IFtoID_PC, IFtoID_inst, imem_addr, 32'hFFFF_FFFC ^ SALT);
    else passCnt++;
  endtask

  task automatic test_random();
    logic [31:0] tgt;
    doReset();
    for (int i = 0; i < 400; i++) begin
      gLat = (i < 200) ? -1 : int'($urandom_range(0, 2));
      tgt  = ($urandom % 8 == 0) ? 32'hFFFF_FFF8 : 32'($urandom_range(0, 1023)) << 2;
      cycle(($urandom % 4) == 0, ($urandom % 10) == 0, tgt);
      checkCnt++;
      if (dutBundle() !== expBundle())
        $display("[TB] FAIL random_%0d got %h exp %h", i, dutBundle(), expBundle());
      else passCnt++;
    end
  endtask

  initial begin
    test_reset();
    test_streaming();
    test_stall();
    test_slow_memory();
    test_redirect_outstanding();
    test_redirect_with_stall();
    test_async_reset();
    test_wrap();
    test_random();
    $display("%0d/%0d checks passed", passCnt, checkCnt);
    $finish;
  end

endmodule
